// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: replays stored 11-bit control words onto the A/B/C transfer/ALU datapath.
// Build option REG_XFER_SEQ_STEP_EN adds a `step` input that ends each dwell instead of tick counting.
module reg_xfer_sequencer #(
  parameter int ADDR_W     = 3,
  parameter int STEP_TICKS = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
`ifdef REG_XFER_SEQ_STEP_EN
  input  logic              step,
`endif
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [10:0]       wr_data,
  output logic              ctrl_xfer,
  output logic [1:0]        ctrl_mux,
  output logic [1:0]        ctrl_alu,
  output logic [1:0]        ctrl_addsub,
  output logic [2:0]        ctrl_load,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);

  localparam int                DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [9:0]        TICK_LAST = 10'(STEP_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_DWELL  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [10:0]       word_r;
  logic [9:0]        tick_cnt_r;
  logic              ctrl_xfer_r;
  logic [1:0]        ctrl_mux_r;
  logic [1:0]        ctrl_alu_r;
  logic [1:0]        ctrl_addsub_r;
  logic [2:0]        ctrl_load_r;
  logic              busy_r;
  logic              done_r;

  logic [10:0]       mem_r [DEPTH];
  logic [10:0]       word_s;
  logic              dwell_end_s;
  logic              tick_cnt_en_s;

  // Program store: written only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_r == ST_IDLE)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign word_s = mem_r[pc_r];

`ifdef REG_XFER_SEQ_STEP_EN
  assign dwell_end_s   = step;
  assign tick_cnt_en_s = 1'b0;
`else
  assign dwell_end_s   = tick && (tick_cnt_r == TICK_LAST);
  assign tick_cnt_en_s = tick;
`endif

  // Sequencer FSM with registered datapath controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      pc_r          <= '0;
      word_r        <= 11'd0;
      tick_cnt_r    <= 10'd0;
      ctrl_xfer_r   <= 1'b0;
      ctrl_mux_r    <= 2'b00;
      ctrl_alu_r    <= 2'b00;
      ctrl_addsub_r <= 2'b00;
      ctrl_load_r   <= 3'b000;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      ctrl_load_r <= 3'b000;
      done_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_FETCH;
            pc_r    <= '0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          word_r  <= word_s;
          state_r <= ST_SETUP;
          // Selects are loaded on this edge so they are already valid during SETUP.
          if (!word_s[10]) begin
            ctrl_xfer_r   <= word_s[9];
            ctrl_mux_r    <= word_s[8:7];
            ctrl_alu_r    <= word_s[6:5];
            ctrl_addsub_r <= word_s[1:0];
          end
        end
        ST_SETUP: begin
          if (word_r[10]) begin
            state_r       <= ST_DONE;
            done_r        <= 1'b1;
            ctrl_xfer_r   <= 1'b0;
            ctrl_mux_r    <= 2'b00;
            ctrl_alu_r    <= 2'b00;
            ctrl_addsub_r <= 2'b00;
          end else begin
            state_r     <= ST_STROBE;
            ctrl_load_r <= word_r[4:2];
          end
        end
        ST_STROBE: begin
          state_r    <= ST_DWELL;
          tick_cnt_r <= 10'd0;
        end
        ST_DWELL: begin
          if (dwell_end_s) begin
            tick_cnt_r <= 10'd0;
            if (pc_r == PC_LAST) begin
              state_r       <= ST_DONE;
              done_r        <= 1'b1;
              ctrl_xfer_r   <= 1'b0;
              ctrl_mux_r    <= 2'b00;
              ctrl_alu_r    <= 2'b00;
              ctrl_addsub_r <= 2'b00;
            end else begin
              state_r <= ST_FETCH;
              pc_r    <= pc_r + ADDR_W'(1);
            end
          end else if (tick_cnt_en_s) begin
            tick_cnt_r <= tick_cnt_r + 10'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r       <= ST_IDLE;
          busy_r        <= 1'b0;
          tick_cnt_r    <= 10'd0;
          ctrl_xfer_r   <= 1'b0;
          ctrl_mux_r    <= 2'b00;
          ctrl_alu_r    <= 2'b00;
          ctrl_addsub_r <= 2'b00;
        end
      endcase
    end
  end

  assign ctrl_xfer   = ctrl_xfer_r;
  assign ctrl_mux    = ctrl_mux_r;
  assign ctrl_alu    = ctrl_alu_r;
  assign ctrl_addsub = ctrl_addsub_r;
  assign ctrl_load   = ctrl_load_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pc          = pc_r;

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Self-checking bench for reg_xfer_sequencer (default build, ADDR_W = 3, STEP_TICKS = 2).
module tb_reg_xfer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [10:0] wr_data = 11'd0;
  logic        ctrl_xfer;
  logic [1:0]  ctrl_mux;
  logic [1:0]  ctrl_alu;
  logic [1:0]  ctrl_addsub;
  logic [2:0]  ctrl_load;
  logic        busy;
  logic        done;
  logic [2:0]  pc;

  int checks = 0;
  int errors = 0;

  int         n_str;
  logic [2:0] str_log [16];
  logic [2:0] str_pc  [16];
  logic [2:0] pc_done;
  bit         pc_rewound;
  bit         timed_out;

  reg_xfer_sequencer #(.ADDR_W(3), .STEP_TICKS(2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ctrl_xfer(ctrl_xfer), .ctrl_mux(ctrl_mux), .ctrl_alu(ctrl_alu),
    .ctrl_addsub(ctrl_addsub), .ctrl_load(ctrl_load),
    .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] word;
    logic        xfer;
    logic [1:0]  mux;
    logic [1:0]  alu;
    logic [1:0]  addsub;
    logic [2:0]  load;
  } vec_t;

  vec_t vecs [6];

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] pk(input logic [6:0] sel, input logic [2:0] ld,
                                     input logic b, input logic d, input logic [2:0] p);
    return {sel, ld, b, d, p};
  endfunction

  function automatic logic [14:0] outs();
    return {ctrl_xfer, ctrl_mux, ctrl_alu, ctrl_addsub, ctrl_load, busy, done, pc};
  endfunction

  task automatic wr(input logic [2:0] a, input logic [10:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step_clk();
    wr_en = 1'b0;
  endtask

  // Launch a run with tick held high, log every strobe, optionally write memory at cycle wr_cyc.
  task automatic run_watch(input int max_cyc, input int wr_cyc);
    bit left_zero;
    left_zero = 1'b0;
    n_str = 0; pc_rewound = 1'b0; timed_out = 1'b1; pc_done = 3'd0;
    for (int k = 0; k < 16; k++) begin
      str_log[k] = 3'd0; str_pc[k] = 3'd0;
    end
    tick = 1'b1; start = 1'b1;
    step_clk();
    start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      wr_en = (c == wr_cyc);
      if (ctrl_load != 3'b000) begin
        if (n_str < 16) begin
          str_log[n_str] = ctrl_load;
          str_pc[n_str]  = pc;
        end
        n_str++;
      end
      if (pc != 3'd0) left_zero = 1'b1;
      else if (left_zero) pc_rewound = 1'b1;
      if (done) begin
        pc_done   = pc;
        timed_out = 1'b0;
        break;
      end
      step_clk();
    end
    wr_en = 1'b0;
    step_clk();
    tick = 1'b0;
  endtask

  initial begin
    logic [6:0]  sel;
    logic [10:0] w;
    logic [2:0]  el;
    bit          found;

    vecs[0] = '{11'h004, 1'b0, 2'b00, 2'b00, 2'b00, 3'b001};
    vecs[1] = '{11'h210, 1'b1, 2'b00, 2'b00, 2'b00, 3'b100};
    vecs[2] = '{11'h1E3, 1'b0, 2'b11, 2'b11, 2'b11, 3'b000};
    vecs[3] = '{11'h2AE, 1'b1, 2'b01, 2'b01, 2'b10, 3'b011};
    vecs[4] = '{11'h0C9, 1'b0, 2'b01, 2'b10, 2'b01, 3'b010};
    vecs[5] = '{11'h31C, 1'b1, 2'b10, 2'b00, 2'b00, 3'b111};

    step_clk(); step_clk();
    chk("reset_outputs", 32'(outs()), 32'(pk(7'd0, 3'd0, 1'b0, 1'b0, 3'd0)));
    rst = 1'b0;
    step_clk();
    chk("idle_outputs", 32'(outs()), 32'(pk(7'd0, 3'd0, 1'b0, 1'b0, 3'd0)));

    // Single-step program per vector, mem[1] is a halt; ticks are held high throughout.
    wr(3'd1, 11'h400);
    for (int i = 0; i < 6; i++) begin
      sel = {vecs[i].xfer, vecs[i].mux, vecs[i].alu, vecs[i].addsub};
      wr(3'd0, vecs[i].word);
      tick = 1'b1; start = 1'b1;
      step_clk();
      start = 1'b0;
      chk($sformatf("v%0d_fetch", i), 32'(outs()), 32'(pk(7'd0, 3'd0, 1'b1, 1'b0, 3'd0)));
      step_clk();
      chk($sformatf("v%0d_setup", i), 32'(outs()), 32'(pk(sel, 3'd0, 1'b1, 1'b0, 3'd0)));
      step_clk();
      chk($sformatf("v%0d_strobe", i), 32'(outs()), 32'(pk(sel, vecs[i].load, 1'b1, 1'b0, 3'd0)));
      step_clk();
      chk($sformatf("v%0d_dwell0", i), 32'(outs()), 32'(pk(sel, 3'd0, 1'b1, 1'b0, 3'd0)));
      step_clk();
      chk($sformatf("v%0d_dwell1", i), 32'(outs()), 32'(pk(sel, 3'd0, 1'b1, 1'b0, 3'd0)));
      step_clk();
      chk($sformatf("v%0d_fetch1", i), 32'(outs()), 32'(pk(sel, 3'd0, 1'b1, 1'b0, 3'd1)));
      step_clk();
      chk($sformatf("v%0d_setup_halt", i), 32'(outs()), 32'(pk(sel, 3'd0, 1'b1, 1'b0, 3'd1)));
      step_clk();
      chk($sformatf("v%0d_done", i), 32'(outs()), 32'(pk(7'd0, 3'd0, 1'b1, 1'b1, 3'd1)));
      step_clk();
      chk($sformatf("v%0d_idle", i), 32'(outs()), 32'(pk(7'd0, 3'd0, 1'b0, 1'b0, 3'd1)));
      tick = 1'b0;
    end

    // No halt anywhere: all eight words execute and the run ends at the last address.
    for (int i = 0; i < 8; i++) begin
      w = 11'h004;
      w = w << (i % 3);
      wr(3'(i), w);
    end
    run_watch(200, -1);
    chk("full_timeout", 32'(timed_out), 32'd0);
    chk("full_strobes", 32'(n_str), 32'd8);
    chk("full_pc_done", 32'(pc_done), 32'd7);
    chk("full_pc_rewound", 32'(pc_rewound), 32'd0);
    for (int k = 0; k < 8; k++) begin
      el = 3'b001;
      el = el << (k % 3);
      chk($sformatf("full_load%0d", k), 32'(str_log[k]), 32'(el));
      chk($sformatf("full_pc%0d", k), 32'(str_pc[k]), 32'(k));
    end

    // Write to mem[0] while busy must be dropped.
    wr(3'd0, 11'h004);
    wr(3'd1, 11'h400);
    wr_addr = 3'd0; wr_data = 11'h010;
    run_watch(100, 3);
    chk("busywr_timeout", 32'(timed_out), 32'd0);
    chk("busywr_strobes", 32'(n_str), 32'd1);
    chk("busywr_pc_done", 32'(pc_done), 32'd1);
    run_watch(100, -1);
    chk("busywr_rerun_load", 32'(str_log[0]), 32'd1);
    chk("busywr_rerun_strobes", 32'(n_str), 32'd1);

    // Reset during the dwell of the second step, then replay from pc 0.
    wr(3'd0, 11'h004);
    wr(3'd1, 11'h008);
    wr(3'd2, 11'h010);
    wr(3'd3, 11'h400);
    tick = 1'b1; start = 1'b1;
    step_clk();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if ((pc == 3'd1) && (ctrl_load == 3'b010)) begin
        found = 1'b1;
        break;
      end
      step_clk();
    end
    chk("rst_reach_step2", 32'(found), 32'd1);
    step_clk();
    chk("rst_in_dwell", 32'(outs()), 32'(pk(7'd0, 3'd0, 1'b1, 1'b0, 3'd1)));
    rst = 1'b1;
    step_clk();
    chk("rst_midrun", 32'(outs()), 32'(pk(7'd0, 3'd0, 1'b0, 1'b0, 3'd0)));
    rst = 1'b0;
    step_clk();
    chk("rst_after_idle", 32'(outs()), 32'(pk(7'd0, 3'd0, 1'b0, 1'b0, 3'd0)));
    tick = 1'b0;
    run_watch(100, -1);
    chk("replay_timeout", 32'(timed_out), 32'd0);
    chk("replay_strobes", 32'(n_str), 32'd3);
    chk("replay_load0", 32'(str_log[0]), 32'd1);
    chk("replay_load1", 32'(str_log[1]), 32'd2);
    chk("replay_load2", 32'(str_log[2]), 32'd4);
    chk("replay_pc_done", 32'(pc_done), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
